param_regfile: RTL and testbench
================================

// Module: param_regfile
// PURPOSE
//   Parametrised multi-port register file, the successor to the fixed 32x64 2R1W file.
//   Width, depth, read-port count and a hardwired-zero register are configurable.
//   Two write ports with deterministic collision priority.
//   Optional write-to-read bypass for same-cycle forwarding.
//   Asynchronous reset. Sits in the CPU decode stage, feeding ALU operands.
// PARAMETERS
//   WIDTH      64   data width of each register, in bits
//   ADDR_BITS  5    address width; DEPTH = 2**ADDR_BITS registers
//   NUM_READ   2    number of read ports (1..4)
//   ZERO_REG   31   index hardwired to 0; set to -1 for no zero register
//   BYPASS     1    1: reads forward same-cycle write data; 0: reads show stored value only
// PORTS
//   clk            in   1                   clock; all state updates on posedge
//   reset          in   1                   asynchronous, active-high; clears all registers
//   ReadRegister   in   NUM_READ*ADDR_BITS  read addresses; port k = [k*ADDR_BITS +: ADDR_BITS]
//   ReadData       out  NUM_READ*WIDTH      read data; port k = [k*WIDTH +: WIDTH]
//   WriteRegister0 in   ADDR_BITS           write port 0 address
//   WriteData0     in   WIDTH               write port 0 data
//   RegWrite0      in   1                   write port 0 enable
//   WriteRegister1 in   ADDR_BITS           write port 1 address
//   WriteData1     in   WIDTH               write port 1 data
//   RegWrite1      in   1                   write port 1 enable
//   Collision      out  1                   registered; 1 for one cycle after a same-address dual write
// BEHAVIOUR
//   Reset
//   - Asserting reset immediately clears every register and Collision to 0, without waiting for clk.
//   - While reset is high, writes are ignored.
//   - The first write after reset is taken at the first posedge on which reset is low.
//   - Because every register reads 0, all ReadData ports read 0 during reset.
//   Writes
//   - At posedge, if RegWriteN=1, reg[WriteRegisterN] <= WriteDataN. Latency 1 cycle.
//   - Collision: RegWrite0 & RegWrite1 with equal addresses.
//     - Port 1 wins; port 0 data is discarded.
//     - Collision <= 1 for exactly the next cycle, else Collision <= 0.
//   - Different addresses: both writes commit in the same cycle.
//   - Writes to ZERO_REG (when ZERO_REG >= 0) are dropped and do not count as a collision.
//     That register always reads 0, including through the bypass path.
//   Reads (combinational, no clock)
//   - ReadData[k] = reg[ReadRegister[k]].
//   - BYPASS=1: if a write port is enabled to the same address as ReadRegister[k], and that
//     address is not ZERO_REG, ReadData[k] shows that port's WriteData in the same cycle.
//     Port 1 takes priority over port 0 (same rule as the collision).
//   - BYPASS=0: the new value appears on the cycle after the posedge that writes it.
//   - Read ports are independent; any number may address the same register.
//   Width rules
//   - No sign extension or truncation; the data path is WIDTH bits end to end.
//   - Addresses use the full 2**ADDR_BITS range; there is no out-of-range case.
//   - Parameter check: ZERO_REG must be less than DEPTH and NUM_READ must be 1..4,
//     otherwise elaboration fails with $error.
// TESTING
//   1. Reset mid-run: write 0xDEAD to r5, then pulse reset between clock edges
//      -> ReadData for r5 = 0 before the next posedge; Collision = 0.
//   2. Zero register: RegWrite0=1, WriteRegister0=31, WriteData0=0xA0 (BYPASS=1)
//      -> r31 reads 0 on the same cycle and on later cycles; Collision stays 0.
//   3. Pattern fill: write i*64'h0000010204080001 to r0..r30 over the two ports in alternation,
//      then read back on all NUM_READ ports -> every value matches; r31 = 0.
//   4. Dual-write collision: port0 writes 0x1111 to r7 and port1 writes 0x2222 to r7 in the same cycle
//      -> after the edge r7 = 0x2222, and Collision = 1 for one cycle then 0.
//   5. Bypass: BYPASS=1, ReadRegister[0]=9, port0 writes 0x55 to r9
//      -> ReadData[0] = 0x55 in the same cycle. Repeat with BYPASS=0
//      -> old value, then 0x55 after the posedge.
//   6. Parametrisation: rebuild with WIDTH=32, ADDR_BITS=4, NUM_READ=3, ZERO_REG=-1
//      -> all 16 registers are writable, including r15 <= 0xFFFFFFFF, and all 3 ports read correctly.

Source files
------------

// File: rtl/param_regfile.sv
// param_regfile: parametrised 2-write, NUM_READ-read register file with optional hardwired-zero register and write bypass
module param_regfile #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 31,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_READ*ADDR_BITS-1:0] ReadRegister,
  output logic [NUM_READ*WIDTH-1:0]     ReadData,
  input  logic [ADDR_BITS-1:0]          WriteRegister0,
  input  logic [WIDTH-1:0]              WriteData0,
  input  logic                          RegWrite0,
  input  logic [ADDR_BITS-1:0]          WriteRegister1,
  input  logic [WIDTH-1:0]              WriteData1,
  input  logic                          RegWrite1,
  output logic                          Collision
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  if (ZERO_REG >= DEPTH || ZERO_REG < -1 || NUM_READ < 1 || NUM_READ > 4) begin : g_bad_params
    $error("param_regfile: ZERO_REG must be -1..DEPTH-1 and NUM_READ 1..4");
  end
  function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
    return ZERO_REG >= 0 && int'(a) == ZERO_REG;
  endfunction
  logic [WIDTH-1:0] regs [DEPTH];
  logic we0, we1, collide;
  // effective enables: reset and the zero register swallow writes, which also keeps them off the bypass path
  assign we0     = RegWrite0 && !reset && !is_zero(WriteRegister0);
  assign we1     = RegWrite1 && !reset && !is_zero(WriteRegister1);
  assign collide = we0 && we1 && WriteRegister0 == WriteRegister1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      Collision <= 1'b0;
    end else begin
      if (we0 && !collide) regs[WriteRegister0] <= WriteData0;
      if (we1) regs[WriteRegister1] <= WriteData1;
      Collision <= collide;
    end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_BITS-1:0] ra;
    assign ra = ReadRegister[k*ADDR_BITS +: ADDR_BITS];
    assign ReadData[k*WIDTH +: WIDTH] =
      BYPASS != 0 && we1 && WriteRegister1 == ra ? WriteData1 :
      BYPASS != 0 && we0 && WriteRegister0 == ra ? WriteData0 : regs[ra];
  end
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed bench with an array model checked every cycle across three configurations
module tb_param_regfile;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic [9:0] rr = '0;
  logic [4:0] wa0 = '0, wa1 = '0;
  logic [63:0] wd0 = '0, wd1 = '0;
  logic we0 = 0, we1 = 0;
  logic [127:0] rd_a, rd_b;
  logic col_a, col_b;
  logic [11:0] c_rr = '0;
  logic [3:0] c_wa0 = '0, c_wa1 = '0;
  logic [31:0] c_wd0 = '0, c_wd1 = '0;
  logic c_we0 = 0, c_we1 = 0;
  logic [95:0] rd_c;
  logic col_c;
  int vectors = 0, errors = 0;

  param_regfile #(.BYPASS(1)) dut_a (.clk(clk), .reset(reset), .ReadRegister(rr), .ReadData(rd_a),
    .WriteRegister0(wa0), .WriteData0(wd0), .RegWrite0(we0), .WriteRegister1(wa1), .WriteData1(wd1),
    .RegWrite1(we1), .Collision(col_a));
  param_regfile #(.BYPASS(0)) dut_b (.clk(clk), .reset(reset), .ReadRegister(rr), .ReadData(rd_b),
    .WriteRegister0(wa0), .WriteData0(wd0), .RegWrite0(we0), .WriteRegister1(wa1), .WriteData1(wd1),
    .RegWrite1(we1), .Collision(col_b));
  param_regfile #(.WIDTH(32), .ADDR_BITS(4), .NUM_READ(3), .ZERO_REG(-1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .ReadRegister(c_rr), .ReadData(rd_c),
    .WriteRegister0(c_wa0), .WriteData0(c_wd0), .RegWrite0(c_we0), .WriteRegister1(c_wa1),
    .WriteData1(c_wd1), .RegWrite1(c_we1), .Collision(col_c));

  logic [63:0] mem [32];
  logic [31:0] mem_c [16];
  logic exp_col = 0, exp_col_c = 0;

  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      for (int i = 0; i < 16; i++) mem_c[i] <= '0;
      exp_col <= 0;
      exp_col_c <= 0;
    end else begin
      if (we0 && wa0 != 31) mem[wa0] <= wd0;
      if (we1 && wa1 != 31) mem[wa1] <= wd1;
      exp_col <= we0 && we1 && wa0 == wa1 && wa0 != 31;
      if (c_we0) mem_c[c_wa0] <= c_wd0;
      if (c_we1) mem_c[c_wa1] <= c_wd1;
      exp_col_c <= c_we0 && c_we1 && c_wa0 == c_wa1;
    end

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 31) return '0;
    if (byp && !reset && we1 && wa1 == a) return wd1;
    if (byp && !reset && we0 && wa0 == a) return wd0;
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_rd_c(input logic [3:0] a);
    if (!reset && c_we1 && c_wa1 == a) return c_wd1;
    if (!reset && c_we0 && c_wa0 == a) return c_wd0;
    return mem_c[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check("model rd_a", rd_a[k*64 +: 64], exp_rd(rr[k*5 +: 5], 1));
      check("model rd_b", rd_b[k*64 +: 64], exp_rd(rr[k*5 +: 5], 0));
    end
    for (int k = 0; k < 3; k++) check("model rd_c", 64'(rd_c[k*32 +: 32]), 64'(exp_rd_c(c_rr[k*4 +: 4])));
    check("model col_a", 64'(col_a), 64'(exp_col));
    check("model col_b", 64'(col_b), 64'(exp_col));
    check("model col_c", 64'(col_c), 64'(exp_col_c));
  end

  task automatic step(); @(posedge clk); #2; endtask
  task automatic mid(); @(negedge clk); endtask
  task automatic wp0(input bit e, input int a, input logic [63:0] d); we0 = e; wa0 = 5'(a); wd0 = d; endtask
  task automatic wp1(input bit e, input int a, input logic [63:0] d); we1 = e; wa1 = 5'(a); wd1 = d; endtask
  task automatic cp0(input bit e, input int a, input logic [31:0] d); c_we0 = e; c_wa0 = 4'(a); c_wd0 = d; endtask
  task automatic cp1(input bit e, input int a, input logic [31:0] d); c_we1 = e; c_wa1 = 4'(a); c_wd1 = d; endtask
  task automatic idle(); we0 = 0; we1 = 0; c_we0 = 0; c_we1 = 0; endtask
  task automatic set_rr(input int a, input int b); rr = {5'(b), 5'(a)}; endtask
  function automatic logic [63:0] pat(input int i); return 64'(i) * 64'h0000010204080001; endfunction
  function automatic logic [31:0] pat_c(input int i); return i == 15 ? 32'hFFFFFFFF : 32'(i + 1) * 32'h01010101; endfunction

  initial begin
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    mid();
    check("reset col", 64'(col_a), 64'd0);
    check("reset rd", rd_a[63:0], 64'd0);
    // write r5 then pulse reset between edges
    step(); wp0(1, 5, 64'hDEAD); set_rr(5, 5);
    step(); idle();
    mid(); check("r5 stored", rd_b[63:0], 64'hDEAD);
    @(posedge clk); #2 reset = 1; #2 reset = 0;
    mid();
    check("r5 after pulse a", rd_a[63:0], 64'd0);
    check("r5 after pulse b", rd_b[63:0], 64'd0);
    check("col after pulse", 64'(col_a), 64'd0);
    // write held across a reset edge is ignored until reset falls
    step(); reset = 1; wp0(1, 3, 64'h77); set_rr(3, 3);
    mid(); check("no bypass in reset", rd_a[63:0], 64'd0);
    step(); reset = 0;
    mid();
    check("write ignored in reset", rd_b[63:0], 64'd0);
    check("bypass after reset", rd_a[63:0], 64'h77);
    step(); idle();
    mid(); check("first write after reset", rd_b[63:0], 64'h77);
    // zero register
    step(); wp0(1, 31, 64'hA0); set_rr(31, 31);
    mid(); check("r31 same cycle", rd_a[63:0], 64'd0);
    step(); idle();
    mid(); check("r31 later", rd_a[63:0], 64'd0); check("r31 col", 64'(col_a), 64'd0);
    step(); wp0(1, 31, 64'h1); wp1(1, 31, 64'h2);
    step(); idle();
    mid(); check("dual r31 no col", 64'(col_a), 64'd0);
    // pattern fill over both ports
    for (int i = 0; i < 31; i += 2) begin
      step(); wp0(1, i, pat(i)); wp1(i + 1 < 31, i + 1, pat(i + 1));
    end
    step(); idle();
    for (int i = 0; i < 32; i += 2) begin
      set_rr(i, i + 1); mid(); step();
    end
    set_rr(3, 31); mid();
    check("r3 pattern", rd_b[63:0], 64'h0000030_60C180003);
    check("r31 after fill", rd_b[127:64], 64'd0);
    // dual-write collision
    step(); wp0(1, 7, 64'h1111); wp1(1, 7, 64'h2222); set_rr(7, 7);
    mid(); check("collide bypass", rd_a[63:0], 64'h2222); check("col before", 64'(col_a), 64'd0);
    step(); idle();
    mid(); check("collide r7", rd_b[63:0], 64'h2222); check("col set", 64'(col_a), 64'd1);
    step();
    mid(); check("col clear", 64'(col_a), 64'd0);
    // bypass vs no bypass
    step(); wp0(1, 9, 64'h55); set_rr(9, 9);
    mid(); check("bypass on", rd_a[63:0], 64'h55); check("bypass off old", rd_b[63:0], 64'h0000091224480009);
    step(); idle();
    mid(); check("bypass off new", rd_b[63:0], 64'h55);
    // narrow config, no zero register
    for (int i = 0; i < 16; i += 2) begin
      step(); cp0(1, i, pat_c(i)); cp1(1, i + 1, pat_c(i + 1));
    end
    step(); idle();
    for (int i = 0; i < 16; i++) begin
      c_rr = {4'((i + 5) % 16), 4'(15 - i), 4'(i)}; mid(); step();
    end
    c_rr = {4'd7, 4'd0, 4'd15}; mid();
    check("c r15", 64'(rd_c[31:0]), 64'hFFFFFFFF);
    check("c r0", 64'(rd_c[63:32]), 64'h01010101);
    check("c r7", 64'(rd_c[95:64]), 64'h08080808);
    step(); cp0(1, 4, 32'h44); cp1(1, 4, 32'h88); c_rr = {4'd4, 4'd4, 4'd4};
    step(); idle();
    mid(); check("c collide", 64'(rd_c[31:0]), 64'h88); check("c col", 64'(col_c), 64'd1);
    step(); mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
